// File: rtl/seg_scan_if.sv
// Value handshake between the display value producer and seg_scan_scheduler.
// The producer drives the master side and the scheduler sits on the slave side.
interface seg_scan_if;
  logic [13:0] value_in;
  logic        value_valid;
  logic        value_ready;

  modport master (
    output value_in,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value_in,
    input  value_valid,
    output value_ready
  );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Four-digit seven-segment scan scheduler with blanking, PWM and frame-synced values.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_scheduler #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   vin,
  input  logic [3:0]  brightness,
  output logic [1:0]  digit_sel,
  output logic [3:0]  cs,
  output logic        blank,
  output logic [13:0] value_out,
  output logic        frame_done
);

  localparam int MAXC = (BLANK_CYCLES > DWELL_CYCLES) ?
                        BLANK_CYCLES : DWELL_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] STEP   = CW'(DWELL_CYCLES / 16);
  localparam logic [CW-1:0] LAST_B = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LAST_D = CW'(DWELL_CYCLES - 1);
  localparam logic [13:0]   VMAX   = 14'd9999;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_ON,
    ST_DARK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] on_q, on_d;
  logic [CW-1:0] bri_w;
  logic [1:0]    dig_q, dig_d;

  logic [13:0]   pend_q, pend_d;
  logic          full_q, full_d;
  logic [13:0]   act_q, act_d;
  logic          rdy_q, rdy_d;

  logic [3:0]    cs_q, cs_d;
  logic          blank_q, blank_d;
  logic          fd_q, fd_d;

  logic          acc;
  logic          bnd;
  logic          lz_ok;
  logic          lit;

  // The counter runs through ON and DARK as one dwell window,
  // so the slot end is the same compare for every brightness.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    on_d    = on_q;
    dig_d   = dig_q;
    bri_w   = CW'(brightness) + CW'(1);
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == LAST_B) begin
          state_d = ST_ON;
          cnt_d   = '0;
          on_d    = bri_w * STEP;
        end
      end
      ST_ON: begin
        if (cnt_q == LAST_D) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          dig_d   = dig_q + 2'd1;
        end else if (cnt_q == on_q - CW'(1)) begin
          state_d = ST_DARK;
        end
      end
      ST_DARK: begin
        if (cnt_q == LAST_D) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          dig_d   = dig_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    acc    = vin.value_valid && rdy_q;
    bnd    = fd_q && full_q;
    pend_d = pend_q;
    full_d = full_q;
    act_d  = act_q;
    if (bnd) begin
      act_d  = pend_q;
      full_d = 1'b0;
    end
    if (acc) begin
      pend_d = (vin.value_in > VMAX) ? VMAX : vin.value_in;
      full_d = 1'b1;
    end
    rdy_d = !full_d;
  end

  always_comb begin
`ifdef SEG_SCAN_LZB_EN
    unique case (1'b1)
      dig_d == 2'd3: lz_ok = act_d >= 14'd1000;
      dig_d == 2'd2: lz_ok = act_d >= 14'd100;
      dig_d == 2'd1: lz_ok = act_d >= 14'd10;
      default:       lz_ok = 1'b1;
    endcase
`else
    lz_ok = 1'b1;
`endif
    lit     = (state_d == ST_ON) && lz_ok;
    cs_d    = lit ? (4'b0001 << dig_d) : 4'b0000;
    blank_d = !lit;
    fd_d    = (state_d != ST_BLANK) && (dig_d == 2'd3) &&
              (cnt_d == LAST_D);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      on_q    <= '0;
      dig_q   <= 2'd0;
      pend_q  <= '0;
      full_q  <= 1'b0;
      act_q   <= '0;
      rdy_q   <= 1'b1;
      cs_q    <= 4'b0000;
      blank_q <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
      dig_q   <= dig_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      act_q   <= act_d;
      rdy_q   <= rdy_d;
      cs_q    <= cs_d;
      blank_q <= blank_d;
      fd_q    <= fd_d;
    end
  end

  assign digit_sel       = dig_q;
  assign cs              = cs_q;
  assign blank           = blank_q;
  assign value_out       = act_q;
  assign frame_done      = fd_q;
  assign vin.value_ready = rdy_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench for seg_scan_scheduler with a time-indexed reference model.
// Expected outputs are derived from slot/frame arithmetic on the cycle count.
module tb_seg_scan_scheduler;

  localparam int DW = 32;
  localparam int BK = 2;
  localparam int SL = DW + BK;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  brightness;
  logic [1:0]  digit_sel;
  logic [3:0]  cs;
  logic        blank;
  logic [13:0] value_out;
  logic        frame_done;

  seg_scan_if u_if ();

  seg_scan_scheduler #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vin        (u_if),
    .brightness (brightness),
    .digit_sel  (digit_sel),
    .cs         (cs),
    .blank      (blank),
    .value_out  (value_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  dig;
    logic [3:0]  cs;
    logic        blank;
    logic [13:0] val;
    logic        fd;
    logic        rdy;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  int   mt     = 0;
  bit   mvalid = 0;
  int   b_slot = 15;
  int   m_act  = 0;
  int   m_pend = 0;
  bit   m_full = 0;
  bit   last_acc = 0;

  function automatic bit shown(int d, int v);
`ifdef SEG_SCAN_LZB_EN
    int lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    return (d == 0) || (v >= lim);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int pick();
    int k = $urandom_range(0, 4);
    case (k)
      0:       return $urandom_range(0, 9);
      1:       return $urandom_range(10, 99);
      2:       return $urandom_range(100, 999);
      3:       return $urandom_range(1000, 9999);
      default: return $urandom_range(10000, 16383);
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // One cycle: queue the expectation for the current cycle, then drive
  // this cycle's inputs and advance the model with them.
  task automatic step(input bit r, input bit vld, input int v,
                      input int br);
    exp_t e;
    int   slot, pos, on;
    bit   lit, fd, acc;
    @(posedge clk);
    #1;
    if (mvalid) begin
      slot    = (mt / SL) % 4;
      pos     = mt % SL;
      on      = (b_slot + 1) * (DW / 16);
      lit     = (pos >= BK) && ((pos - BK) < on) && shown(slot, m_act);
      e.dig   = slot[1:0];
      e.cs    = lit ? 4'(1 << slot) : 4'd0;
      e.blank = !lit;
      e.val   = m_act[13:0];
      e.fd    = (slot == 3) && (pos == SL - 1);
      e.rdy   = !m_full;
      sbq.push_back(e);
    end
    rst_n             = r;
    u_if.value_valid  = vld;
    u_if.value_in     = v[13:0];
    brightness        = br[3:0];
    last_acc          = 0;
    if (!r) begin
      mt     = 0;
      m_act  = 0;
      m_pend = 0;
      m_full = 0;
      mvalid = 1;
    end else if (mvalid) begin
      slot = (mt / SL) % 4;
      pos  = mt % SL;
      if (pos == BK - 1) b_slot = br;
      fd  = (slot == 3) && (pos == SL - 1);
      acc = vld && !m_full;
      if (fd && m_full) begin
        m_act  = m_pend;
        m_full = 0;
      end
      if (acc) begin
        m_pend   = (v > 9999) ? 9999 : v;
        m_full   = 1;
        last_acc = 1;
      end
      mt++;
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("digit_sel",   32'(digit_sel),   32'(mon_e.dig));
      chk("cs",          32'(cs),          32'(mon_e.cs));
      chk("blank",       32'(blank),       32'(mon_e.blank));
      chk("value_out",   32'(value_out),   32'(mon_e.val));
      chk("frame_done",  32'(frame_done),  32'(mon_e.fd));
      chk("value_ready", 32'(u_if.value_ready), 32'(mon_e.rdy));
    end
  end

  initial begin
    bit off;
    int ov;
    int br;
    bit r;
    rst_n            = 1'b0;
    u_if.value_valid = 1'b0;
    u_if.value_in    = '0;
    brightness       = 4'd15;

    // scan timing at full brightness
    step(0, 0, 0, 15);
    step(0, 0, 0, 15);
    repeat (280) step(1, 0, 0, 15);

    // PWM, brightness drops to 0 during slot 1 ON
    step(0, 0, 0, 3);
    for (int i = 0; i < 140; i++) step(1, 0, 0, (mt >= 39) ? 0 : 3);

    // handshake with a held second offer
    step(0, 0, 0, 15);
    off = 0;
    ov  = 0;
    for (int i = 0; i < 300; i++) begin
      if (last_acc) off = 0;
      if (mt == 10) begin off = 1; ov = 1234; end
      if (mt == 20) begin off = 1; ov = 5678; end
      step(1, off, ov, 15);
    end

    // saturation offered exactly on the frame boundary
    step(0, 0, 0, 15);
    for (int i = 0; i < 300; i++)
      step(1, (mt == 4 * SL - 1), 12000, 15);

    // small value for leading-zero behaviour
    step(0, 0, 0, 15);
    off = 0;
    for (int i = 0; i < 300; i++) begin
      if (last_acc) off = 0;
      if (mt == 5) begin off = 1; ov = 42; end
      step(1, off, ov, 15);
    end

    // reset during slot 2 ON with a pending value
    step(0, 0, 0, 15);
    off = 0;
    for (int i = 0; i < 73; i++) begin
      if (last_acc) off = 0;
      if (mt == 10) begin off = 1; ov = 777; end
      step(1, off, ov, 15);
    end
    step(0, 0, 0, 15);
    repeat (300) step(1, 0, 0, 15);

    // randomized traffic
    off = 0;
    br  = 15;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) br = $urandom_range(0, 15);
      if (last_acc) off = 0;
      if (!off && $urandom_range(0, 9) == 0) begin
        off = 1;
        ov  = pick();
      end
      r = ($urandom_range(0, 999) != 0);
      step(r, off, ov, br);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
